// File: rtl/regfile_pkg.sv
// Shared configuration and helpers for the multi-port register file.
// The optional write-first bypass is enabled with REGFILE_WR_BYPASS_EN.
package regfile_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 4;
  localparam int NREGS   = 15;
  localparam int PC_ADDR = 15;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // True when the address names a physical register (not r15, not out of range).
  function automatic logic is_phys(input logic [ADDR_W-1:0] a);
    logic hit;
    hit = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      if (r != PC_ADDR && a == ADDR_W'(r)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per physical register, busy lookup per read port.
// REGFILE_WR_BYPASS_EN also suppresses busy for a same-cycle writeback.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] wa_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] wa_b,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] ra3,
  output logic              busy1,
  output logic              busy2,
  output logic              busy3
);

  logic [NREGS-1:0] pending_q, pending_d;
  logic [NREGS-1:0] wr_hit, set_hit;

  function automatic logic bit_at(input logic [ADDR_W-1:0] a, input logic [NREGS-1:0] vec);
    logic res;
    res = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      if (r != PC_ADDR && a == ADDR_W'(r)) res = vec[r];
    end
    return res;
  endfunction

  // A newly issued producer (set) outranks the writeback of the previous one (clear).
  always_comb begin
    wr_hit    = '0;
    set_hit   = '0;
    pending_d = pending_q;
    for (int r = 0; r < NREGS; r++) begin
      if (r != PC_ADDR) begin
        wr_hit[r]  = (we_a && wa_a == ADDR_W'(r)) || (we_b && wa_b == ADDR_W'(r));
        set_hit[r] = sb_set && sb_addr == ADDR_W'(r);
      end
      pending_d[r] = set_hit[r] | (pending_q[r] & ~wr_hit[r]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending_q <= '0;
    else          pending_q <= pending_d;
  end

`ifdef REGFILE_WR_BYPASS_EN
  assign busy1 = bit_at(ra1, pending_q) & ~(bit_at(ra1, wr_hit) & ~bit_at(ra1, set_hit));
  assign busy2 = bit_at(ra2, pending_q) & ~(bit_at(ra2, wr_hit) & ~bit_at(ra2, set_hit));
  assign busy3 = bit_at(ra3, pending_q) & ~(bit_at(ra3, wr_hit) & ~bit_at(ra3, set_hit));
`else
  assign busy1 = bit_at(ra1, pending_q);
  assign busy2 = bit_at(ra2, pending_q);
  assign busy3 = bit_at(ra3, pending_q);
`endif

endmodule

// File: rtl/regfile_mp.sv
// Three-read / two-write register file with r15 passthrough and a pending-write scoreboard.
// Define REGFILE_WR_BYPASS_EN for write-first read bypass.
module regfile_mp
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] ra3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] rd3,
  input  logic [DATA_W-1:0] r15,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] wa_a,
  input  logic [DATA_W-1:0] wd_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] wa_b,
  input  logic [DATA_W-1:0] wd_b,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              busy3
);

  logic [NREGS-1:0][DATA_W-1:0] rf_q;
  logic [NREGS-1:0]             hit_a, hit_b;

  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int r = 0; r < NREGS; r++) begin
      if (r != PC_ADDR) begin
        hit_a[r] = we_a && wa_a == ADDR_W'(r);
        hit_b[r] = we_b && wa_b == ADDR_W'(r);
      end
    end
  end

  // Port A has priority when both ports target the same register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (hit_a[r])      rf_q[r] <= wd_a;
        else if (hit_b[r]) rf_q[r] <= wd_b;
      end
    end
  end

  function automatic logic [DATA_W-1:0] stored_read(
    input logic [ADDR_W-1:0]             a,
    input logic [NREGS-1:0][DATA_W-1:0] rf,
    input logic [DATA_W-1:0]             pc_val
  );
    logic [DATA_W-1:0] res;
    res = '0;
    if (a == ADDR_W'(PC_ADDR)) begin
      res = pc_val;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (r != PC_ADDR && a == ADDR_W'(r)) res = rf[r];
      end
    end
    return res;
  endfunction

`ifdef REGFILE_WR_BYPASS_EN
  function automatic logic [DATA_W-1:0] bypass_read(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic              en_a,
    input logic [ADDR_W-1:0] addr_a,
    input logic [DATA_W-1:0] data_a,
    input logic              en_b,
    input logic [ADDR_W-1:0] addr_b,
    input logic [DATA_W-1:0] data_b
  );
    logic [DATA_W-1:0] res;
    res = stored;
    if (is_phys(a) && en_a && addr_a == a)      res = data_a;
    else if (is_phys(a) && en_b && addr_b == a) res = data_b;
    return res;
  endfunction

  assign rd1 = bypass_read(ra1, stored_read(ra1, rf_q, r15), we_a, wa_a, wd_a, we_b, wa_b, wd_b);
  assign rd2 = bypass_read(ra2, stored_read(ra2, rf_q, r15), we_a, wa_a, wd_a, we_b, wa_b, wd_b);
  assign rd3 = bypass_read(ra3, stored_read(ra3, rf_q, r15), we_a, wa_a, wd_a, we_b, wa_b, wd_b);
`else
  assign rd1 = stored_read(ra1, rf_q, r15);
  assign rd2 = stored_read(ra2, rf_q, r15);
  assign rd3 = stored_read(ra3, rf_q, r15);
`endif

  regfile_scoreboard u_sb (
    .clk     (clk),
    .reset_n (reset_n),
    .we_a    (we_a),
    .wa_a    (wa_a),
    .we_b    (we_b),
    .wa_b    (wa_b),
    .sb_set  (sb_set),
    .sb_addr (sb_addr),
    .ra1     (ra1),
    .ra2     (ra2),
    .ra3     (ra3),
    .busy1   (busy1),
    .busy2   (busy2),
    .busy3   (busy3)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed table, hand sequences, random vs. array model.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] ra1, ra2, ra3, wa_a, wa_b, sb_addr;
  logic [DATA_W-1:0] rd1, rd2, rd3, r15, wd_a, wd_b;
  logic              we_a, we_b, sb_set, busy1, busy2, busy3;

  regfile_mp dut (
    .clk(clk), .reset_n(reset_n),
    .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .rd1(rd1), .rd2(rd2), .rd3(rd3),
    .r15(r15),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .busy1(busy1), .busy2(busy2), .busy3(busy3)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: plain arrays indexed by register number
  logic [DATA_W-1:0] rf_m   [NREGS];
  bit                pend_m [NREGS];
  logic [DATA_W-1:0] exp_q [$];

  typedef struct {
    logic wea; logic [3:0] waa; logic [31:0] wda;
    logic web; logic [3:0] wab; logic [31:0] wdb;
    logic sbs; logic [3:0] sba;
    logic [3:0] a1, a2, a3;
    logic [31:0] e1, e2, e3;
    logic [2:0] eb;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) begin
      rf_m[i]   = '0;
      pend_m[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [3:0] a);
    int ai;
    ai = int'(a);
    if (ai == PC_ADDR) return r15;
    if (ai >= NREGS) return 32'h0;
`ifdef REGFILE_WR_BYPASS_EN
    if (we_a && wa_a == a) return wd_a;
    if (we_b && wa_b == a) return wd_b;
`endif
    return rf_m[ai];
  endfunction

  function automatic logic [31:0] exp_busy(input logic [3:0] a);
    int ai;
    bit b;
    ai = int'(a);
    if (ai >= NREGS || ai == PC_ADDR) return 32'h0;
    b = pend_m[ai];
`ifdef REGFILE_WR_BYPASS_EN
    if (((we_a && wa_a == a) || (we_b && wa_b == a)) && !(sb_set && sb_addr == a)) b = 1'b0;
`endif
    return {31'b0, b};
  endfunction

  // Apply the clock-edge rules to the model using the inputs currently driven.
  task automatic model_edge();
    int wa, wb, sa;
    wa = int'(wa_a);
    wb = int'(wb_b_val());
    sa = int'(sb_addr);
    if (we_b && wb < NREGS && wb != PC_ADDR) begin
      rf_m[wb] = wd_b;
      pend_m[wb] = 1'b0;
    end
    if (we_a && wa < NREGS && wa != PC_ADDR) begin
      rf_m[wa] = wd_a;
      pend_m[wa] = 1'b0;
    end
    if (sb_set && sa < NREGS && sa != PC_ADDR) pend_m[sa] = 1'b1;
  endtask

  function automatic logic [3:0] wb_b_val();
    return wa_b;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_a = 1'b0; we_b = 1'b0; sb_set = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] act [6];
    string nm [6];
    nm  = '{"rd1", "rd2", "rd3", "busy1", "busy2", "busy3"};
    act = '{rd1, rd2, rd3, {31'b0, busy1}, {31'b0, busy2}, {31'b0, busy3}};
    exp_q.push_back(exp_rd(ra1));
    exp_q.push_back(exp_rd(ra2));
    exp_q.push_back(exp_rd(ra3));
    exp_q.push_back(exp_busy(ra1));
    exp_q.push_back(exp_busy(ra2));
    exp_q.push_back(exp_busy(ra3));
    for (int i = 0; i < 6; i++) check($sformatf("%s.%s", tag, nm[i]), act[i], exp_q.pop_front());
  endtask

  initial begin
    logic [31:0] exp_same;

    vecs[0] = '{1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd3, 4'd0, 4'd15, 32'hDEADBEEF, 32'h0, 32'h108, 3'b000};
    vecs[1] = '{1'b1, 4'd5, 32'h11, 1'b1, 4'd5, 32'h22, 1'b0, 4'd0, 4'd5, 4'd3, 4'd6, 32'h11, 32'hDEADBEEF, 32'h0, 3'b000};
    vecs[2] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd6, 32'h33, 1'b0, 4'd0, 4'd6, 4'd5, 4'd14, 32'h33, 32'h11, 32'h0, 3'b000};
    vecs[3] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 4'd7, 4'd6, 4'd7, 32'h0, 32'h33, 32'h0, 3'b101};
    vecs[4] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 32'h77, 1'b0, 4'd0, 4'd7, 4'd7, 4'd3, 32'h77, 32'h77, 32'hDEADBEEF, 3'b000};
    vecs[5] = '{1'b1, 4'd7, 32'h70, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 4'd7, 4'd1, 4'd2, 32'h70, 32'h0, 32'h0, 3'b100};
    vecs[6] = '{1'b1, 4'd15, 32'hFFFFFFFF, 1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 4'd15, 4'd7, 4'd0, 32'h108, 32'h70, 32'h0, 3'b010};
    vecs[7] = '{1'b1, 4'd14, 32'h1234, 1'b1, 4'd14, 32'h5678, 1'b1, 4'd2, 4'd14, 4'd2, 4'd15, 32'h1234, 32'h0, 32'h108, 3'b010};
    vecs[8] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 32'h55, 1'b0, 4'd0, 4'd2, 4'd14, 4'd7, 32'h55, 32'h1234, 32'h70, 3'b001};
    vecs[9] = '{1'b1, 4'd7, 32'h99, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd7, 4'd8, 4'd2, 32'h99, 32'h0, 32'h55, 3'b000};

    // reset with a pending write attempt that must not land
    reset_n = 1'b0;
    r15 = 32'h0000_0108;
    ra1 = '0; ra2 = '0; ra3 = '0;
    wa_a = 4'd1; wd_a = 32'h1; wa_b = '0; wd_b = '0; sb_addr = 4'd1;
    we_a = 1'b1; we_b = 1'b0; sb_set = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold.rd1", rd1, 32'h0);
    check("rst_hold.busy1", {31'b0, busy1}, 32'h0);
    idle();
    reset_n = 1'b1;

    // reset contents: every physical register reads 0, r15 passes through
    for (int a = 0; a < NREGS; a++) begin
      ra1 = 4'(a); ra2 = 4'(NREGS - 1 - a); ra3 = 4'(a);
      #1;
      check($sformatf("rst.rd1[%0d]", a), rd1, 32'h0);
      check($sformatf("rst.rd2[%0d]", a), rd2, 32'h0);
      check($sformatf("rst.busy3[%0d]", a), {31'b0, busy3}, 32'h0);
    end
    ra1 = 4'd15;
    #1;
    check("rst.r15", rd1, 32'h0000_0108);

    // same-cycle write/read of r3
    we_a = 1'b1; wa_a = 4'd3; wd_a = 32'hDEAD_BEEF; ra1 = 4'd3;
    #1;
`ifdef REGFILE_WR_BYPASS_EN
    exp_same = 32'hDEAD_BEEF;
`else
    exp_same = 32'h0;
`endif
    check("same_cycle.rd1", rd1, exp_same);
    tick();
    idle();
    #1;
    check("next_cycle.rd1", rd1, 32'hDEAD_BEEF);

    // directed table: pre-edge against the model, post-edge against constants
    for (int i = 0; i < 10; i++) begin
      we_a = vecs[i].wea; wa_a = vecs[i].waa; wd_a = vecs[i].wda;
      we_b = vecs[i].web; wa_b = vecs[i].wab; wd_b = vecs[i].wdb;
      sb_set = vecs[i].sbs; sb_addr = vecs[i].sba;
      ra1 = vecs[i].a1; ra2 = vecs[i].a2; ra3 = vecs[i].a3;
      #1;
      check_all($sformatf("vec%0d.pre", i));
      tick();
      idle();
      #1;
      check($sformatf("vec%0d.rd1", i), rd1, vecs[i].e1);
      check($sformatf("vec%0d.rd2", i), rd2, vecs[i].e2);
      check($sformatf("vec%0d.rd3", i), rd3, vecs[i].e3);
      check($sformatf("vec%0d.busy", i), {29'b0, busy1, busy2, busy3}, {29'b0, vecs[i].eb});
    end

    // asynchronous reset mid-cycle with r2 written and r4 pending
    we_a = 1'b1; wa_a = 4'd2; wd_a = 32'h55; sb_set = 1'b1; sb_addr = 4'd4;
    tick();
    idle();
    ra1 = 4'd2; ra2 = 4'd4;
    #1;
    check("pre_rst.rd1", rd1, 32'h55);
    check("pre_rst.busy2", {31'b0, busy2}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst.rd1", rd1, 32'h0);
    check("async_rst.busy2", {31'b0, busy2}, 32'h0);
    we_a = 1'b1; wa_a = 4'd9; wd_a = 32'hCAFE; ra3 = 4'd9;
    @(posedge clk);
    #1;
    idle();
    check("rst_edge_nowrite.rd3", rd3, 32'h0);
    reset_n = 1'b1;
    model_clear();
    #1;
    check("post_rst.rd3", rd3, 32'h0);

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      we_a = 1'($urandom_range(0, 1)); wa_a = 4'($urandom_range(0, 15)); wd_a = $urandom;
      we_b = 1'($urandom_range(0, 1)); wa_b = 4'($urandom_range(0, 15)); wd_b = $urandom;
      sb_set = ($urandom_range(0, 2) == 0); sb_addr = 4'($urandom_range(0, 15));
      ra1 = 4'($urandom_range(0, 15)); ra2 = 4'($urandom_range(0, 15)); ra3 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) ra2 = wa_a;
      if ($urandom_range(0, 7) == 0) ra3 = sb_addr;
      r15 = $urandom;
      #1;
      check_all($sformatf("rnd%0d", c));
      tick();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
